// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ local requesters.
// Runs the SETUP/ACCESS handshake itself and returns a one-cycle ack with rdata/err.
module apb_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DATA    = 32,
  parameter int unsigned ADDR    = 32,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*DATA-1:0] req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [DATA-1:0]      rdata,
  output logic                 err,
  output logic [IDW-1:0]       gnt_id,
  output logic [ADDR-1:0]      paddr,
  output logic                 pwrite,
  output logic [DATA-1:0]      pwdata,
  output logic                 psel,
  output logic                 penable,
  input  logic                 pready,
  input  logic [DATA-1:0]      prdata,
  input  logic                 pslverr
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   tcnt;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  ptr_next;
  logic [ADDR-1:0] win_addr;
  logic [DATA-1:0] win_wdata;
  logic            win_rw;

  // A requester being acked this cycle still holds req; keep it out of the race.
  assign elig = req & ~ack;

  // Round-robin search starting at ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign ptr_next  = IDW'((32'(win) + 32'd1) % NREQ);
  assign win_addr  = req_addr[32'(win)*ADDR +: ADDR];
  assign win_wdata = req_wdata[32'(win)*DATA +: DATA];
  assign win_rw    = req_rw[win];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= S_IDLE;
      ptr     <= '0;
      tcnt    <= '0;
      ack     <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      gnt_id  <= '0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          paddr   <= '0;
          pwrite  <= 1'b0;
          pwdata  <= '0;
          if (found) begin
            state  <= S_SETUP;
            psel   <= 1'b1;
            gnt_id <= win;
            ptr    <= ptr_next;
            tcnt   <= '0;
            paddr  <= win_addr;
            pwrite <= win_rw;
            pwdata <= win_rw ? win_wdata : '0;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
        end
        S_ACCESS: begin
          if (pready || ((TIMEOUT != 0) && (32'(tcnt) + 32'd1 == TIMEOUT))) begin
            // Completion: return the bus to idle and pulse ack to the owner.
            state   <= S_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            ack     <= NREQ'(1) << gnt_id;
            if (pready) begin
              err   <= pslverr;
              rdata <= pwrite ? '0 : prdata;
            end else begin
              err   <= 1'b1;
              rdata <= '0;
            end
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scenario bench for apb_req_arbiter: directed cases plus randomized rounds
// checked against a pending-set / round-robin reference model.
module tb_apb_req_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DATA    = 32;
  localparam int unsigned ADDR    = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] KEY     = 32'hA5A5_5A5A;

  logic                 pclk = 1'b0;
  logic                 presetn;
  logic [NREQ-1:0]      req, req_rw;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_wdata;
  logic [NREQ-1:0]      ack;
  logic [DATA-1:0]      rdata;
  logic                 err;
  logic [1:0]           gnt_id;
  logic [ADDR-1:0]      paddr;
  logic                 pwrite;
  logic [DATA-1:0]      pwdata;
  logic                 psel, penable;
  logic                 pready;
  logic [DATA-1:0]      prdata;
  logic                 pslverr;

  apb_req_arbiter #(.NREQ(NREQ), .DATA(DATA), .ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .gnt_id(gnt_id),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct { int id; logic [31:0] rdata; logic err; int cyc; int acc; } ack_t;
  typedef struct { logic [31:0] addr; logic rw; logic [31:0] wdata; int gnt; } setup_t;

  ack_t   ack_q[$];
  setup_t setup_q[$];

  int n_pass = 0, n_total = 0;
  int cyc = 0, acc_cnt = 0, acc_cycles = 0, onehot_bad = 0, stab_bad = 0;
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_rw;
  bit          slv_auto = 0, scramble = 0;
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 0, slv_err_wait = 0;

  function automatic int rr_pick(int p, logic [3:0] pend);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(int i, logic rw, logic [31:0] a, logic [31:0] d);
    req_rw[i]             = rw;
    req_addr[i*ADDR +: ADDR]  = a;
    req_wdata[i*DATA +: DATA] = d;
  endtask

  task automatic clear_log();
    ack_q.delete();
    setup_q.delete();
  endtask

  // One clock: observe outputs, act as requesters and as the APB slave.
  task automatic tick();
    int w;
    @(posedge pclk); #1;
    cyc++;
    if (ack != '0) begin
      ack_t e;
      e.id = -1;
      for (int i = 0; i < 4; i++) if (ack[i]) e.id = i;
      e.rdata = rdata; e.err = err; e.cyc = cyc; e.acc = acc_cycles;
      ack_q.push_back(e);
      if ($countones(ack) != 1) onehot_bad++;
      for (int i = 0; i < 4; i++) if (ack[i]) req[i] = 1'b0;
    end
    if (psel && !penable) begin
      setup_t s;
      s.addr = paddr; s.rw = pwrite; s.wdata = pwdata; s.gnt = int'(gnt_id);
      setup_q.push_back(s);
      cur_addr = paddr; cur_rw = pwrite; cur_wdata = pwdata; acc_cycles = 0;
      if (scramble) set_req(int'(gnt_id), ~req_rw[gnt_id], $urandom, $urandom);
    end
    if (psel && penable) begin
      acc_cycles++;
      if (paddr !== cur_addr || pwrite !== cur_rw || pwdata !== cur_wdata) stab_bad++;
    end
    if (psel && penable) begin
      w = slv_auto ? int'(paddr[1:0]) : slv_wait;
      pready = (acc_cnt >= w);
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
    prdata  = slv_auto ? (paddr ^ KEY) : slv_rdata;
    pslverr = slv_auto ? paddr[2] : (pready ? slv_err : slv_err_wait);
  endtask

  task automatic reset_dut();
    presetn = 1'b0;
    tick(); tick();
    req = '0;
    presetn = 1'b1;
  endtask

  task automatic test_reset();
    #2 presetn = 1'b0;
    #1;
    n_total++; if (ack !== 4'b0) $display("FAIL rst_ack: got %b expected 0000", ack); else n_pass++;
    n_total++; if ({psel, penable, pwrite, err} !== 4'b0) $display("FAIL rst_ctl: got %b expected 0000", {psel, penable, pwrite, err}); else n_pass++;
    n_total++; if (paddr !== 32'h0 || pwdata !== 32'h0) $display("FAIL rst_bus: got %h/%h expected 0/0", paddr, pwdata); else n_pass++;
    n_total++; if (rdata !== 32'h0 || gnt_id !== 2'd0) $display("FAIL rst_rdata_gnt: got %h/%0d expected 0/0", rdata, gnt_id); else n_pass++;
    tick(); tick();
    presetn = 1'b1;
  endtask

  task automatic test_single_write();
    clear_log();
    slv_auto = 0; slv_wait = 0; slv_err = 0; slv_err_wait = 0; slv_rdata = 32'h0BAD_F00D;
    set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    req[0] = 1'b1;
    tick();
    n_total++; if ({psel, penable} !== 2'b10) $display("FAIL sw_setup: got %b expected 10", {psel, penable}); else n_pass++;
    n_total++; if (paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1)
      $display("FAIL sw_bus: got %h/%h/%b expected 10/deadbeef/1", paddr, pwdata, pwrite); else n_pass++;
    set_req(0, 1'b0, 32'hFFFF_FFF0, 32'h1);
    tick();
    n_total++; if ({psel, penable} !== 2'b11) $display("FAIL sw_access: got %b expected 11", {psel, penable}); else n_pass++;
    n_total++; if (paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) $display("FAIL sw_stable: got %h/%h expected 10/deadbeef", paddr, pwdata); else n_pass++;
    tick();
    n_total++; if (ack !== 4'b0001 || err !== 1'b0) $display("FAIL sw_ack: got %b/%b expected 0001/0", ack, err); else n_pass++;
    n_total++; if ({psel, penable} !== 2'b00 || rdata !== 32'h0) $display("FAIL sw_idle: got %b/%h expected 00/0", {psel, penable}, rdata); else n_pass++;
    tick();
    n_total++; if (ack !== 4'b0 || psel !== 1'b0) $display("FAIL sw_pulse: got %b/%b expected 0000/0", ack, psel); else n_pass++;
  endtask

  task automatic test_read_wait();
    int n;
    clear_log();
    slv_wait = 3; slv_rdata = 32'h1234_5678; slv_err = 0;
    set_req(2, 1'b0, 32'h40, 32'hCAFE_F00D);
    req[2] = 1'b1;
    n = 0;
    while (n < 20) begin
      tick(); n++;
      if (ack != '0) break;
    end
    n_total++; if (n !== 6) $display("FAIL rd_latency: got %0d expected 6", n); else n_pass++;
    n_total++; if (ack !== 4'b0100 || gnt_id !== 2'd2) $display("FAIL rd_ack: got %b/%0d expected 0100/2", ack, gnt_id); else n_pass++;
    n_total++; if (rdata !== 32'h1234_5678 || err !== 1'b0) $display("FAIL rd_data: got %h/%b expected 12345678/0", rdata, err); else n_pass++;
    n_total++; if (stab_bad !== 0) $display("FAIL rd_stable: got %0d unstable cycles expected 0", stab_bad); else n_pass++;
    n_total++;
    if (setup_q.size() != 1) $display("FAIL rd_setup: got %0d setups expected 1", setup_q.size());
    else if (setup_q[0].addr !== 32'h40 || setup_q[0].wdata !== 32'h0 || setup_q[0].rw !== 1'b0)
      $display("FAIL rd_setup: got %h/%h/%b expected 40/0/0", setup_q[0].addr, setup_q[0].wdata, setup_q[0].rw);
    else n_pass++;
    tick();
  endtask

  task automatic test_fairness();
    int   exp_ids[4];
    int   m_ptr, w;
    logic [3:0] pend;
    bit   raise_next;
    int   raise_cnt;
    reset_dut();
    clear_log();
    slv_wait = 0;
    m_ptr = 0; pend = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      w = rr_pick(m_ptr, pend);
      exp_ids[g] = w;
      pend[w] = 1'b0;
      m_ptr = (w + 1) % 4;
      if (g == 0) pend[0] = 1'b1;
    end
    set_req(0, 1'b1, 32'h100, 32'h0);
    set_req(1, 1'b1, 32'h104, 32'h1);
    set_req(3, 1'b1, 32'h10C, 32'h3);
    req = 4'b1011;
    raise_next = 0; raise_cnt = 0;
    for (int n = 0; n < 40 && ack_q.size() < 4; n++) begin
      tick();
      if (raise_next) begin req[0] = 1'b1; raise_next = 0; end
      if (ack[0] && raise_cnt == 0) begin raise_next = 1; raise_cnt = 1; end
    end
    n_total++; if (ack_q.size() != 4) $display("FAIL fair_count: got %0d acks expected 4", ack_q.size()); else n_pass++;
    for (int g = 0; g < 4 && g < ack_q.size(); g++) begin
      n_total++; if (ack_q[g].id != exp_ids[g]) $display("FAIL fair_order%0d: got %0d expected %0d", g, ack_q[g].id, exp_ids[g]); else n_pass++;
      if (g > 0) begin
        n_total++; if (ack_q[g].cyc - ack_q[g-1].cyc != 3)
          $display("FAIL fair_gap%0d: got %0d expected 3", g, ack_q[g].cyc - ack_q[g-1].cyc); else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    clear_log();
    slv_wait = 1000; slv_rdata = 32'hFFFF_FFFF;
    set_req(1, 1'b0, 32'h80, 32'h0);
    req[1] = 1'b1;
    for (int n = 0; n < 40 && ack == '0; n++) tick();
    n_total++; if (ack !== 4'b0010) $display("FAIL to_ack: got %b expected 0010", ack); else n_pass++;
    n_total++; if (ack_q.size() != 1 || ack_q[0].acc != 16)
      $display("FAIL to_cycles: got %0d access cycles expected 16", (ack_q.size() > 0) ? ack_q[0].acc : -1); else n_pass++;
    n_total++; if (err !== 1'b1 || rdata !== 32'h0) $display("FAIL to_err: got %b/%h expected 1/0", err, rdata); else n_pass++;
    n_total++; if ({psel, penable} !== 2'b00) $display("FAIL to_idle: got %b expected 00", {psel, penable}); else n_pass++;
    tick();
  endtask

  task automatic test_slverr();
    clear_log();
    slv_wait = 0; slv_err = 1; slv_err_wait = 0;
    set_req(3, 1'b1, 32'h20, 32'h55AA);
    req[3] = 1'b1;
    for (int n = 0; n < 20 && ack == '0; n++) tick();
    n_total++; if (ack !== 4'b1000 || err !== 1'b1) $display("FAIL se_err: got %b/%b expected 1000/1", ack, err); else n_pass++;
    tick(); tick();
    n_total++; if (err !== 1'b1) $display("FAIL se_hold: got %b expected 1", err); else n_pass++;
    slv_wait = 2; slv_err = 0; slv_err_wait = 1; slv_rdata = 32'h0F0F_0F0F;
    set_req(2, 1'b0, 32'h24, 32'h0);
    req[2] = 1'b1;
    for (int n = 0; n < 20 && ack == '0; n++) tick();
    n_total++; if (ack !== 4'b0100 || err !== 1'b0) $display("FAIL se_clear: got %b/%b expected 0100/0", ack, err); else n_pass++;
    n_total++; if (rdata !== 32'h0F0F_0F0F) $display("FAIL se_rdata: got %h expected 0f0f0f0f", rdata); else n_pass++;
    slv_err_wait = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    clear_log();
    slv_wait = 1000;
    set_req(0, 1'b0, 32'h30, 32'h0);
    req[0] = 1'b1;
    for (int n = 0; n < 10 && !penable; n++) tick();
    tick(); tick();
    set_req(1, 1'b1, 32'h34, 32'h77);
    req[1] = 1'b1;
    #2 presetn = 1'b0;
    #1;
    n_total++; if ({psel, penable} !== 2'b00 || paddr !== 32'h0 || ack !== 4'b0)
      $display("FAIL rm_async: got %b/%h/%b expected 00/0/0000", {psel, penable}, paddr, ack); else n_pass++;
    tick(); tick();
    req[0] = 1'b0;
    presetn = 1'b1;
    clear_log();
    slv_wait = 0;
    for (int n = 0; n < 20 && ack == '0; n++) tick();
    n_total++; if (setup_q.size() < 1 || setup_q[0].gnt != 1)
      $display("FAIL rm_first: got %0d expected 1", (setup_q.size() > 0) ? setup_q[0].gnt : -1); else n_pass++;
    n_total++; if (ack !== 4'b0010 || ack_q.size() != 1) $display("FAIL rm_ack: got %b/%0d expected 0010/1", ack, ack_q.size()); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a_exp[4], d_exp[4];
    logic        rw_exp[4];
    int          order[$];
    int          m_ptr, w;
    logic [3:0]  mask, pend;
    reset_dut();
    slv_auto = 1; scramble = 1;
    m_ptr = 0;
    for (int r = 0; r < 25; r++) begin
      tick();
      clear_log();
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        a_exp[i] = $urandom; d_exp[i] = $urandom; rw_exp[i] = 1'($urandom_range(0, 1));
        set_req(i, rw_exp[i], a_exp[i], d_exp[i]);
      end
      order.delete();
      pend = mask;
      while (pend != 4'b0) begin
        w = rr_pick(m_ptr, pend);
        order.push_back(w);
        pend[w] = 1'b0;
        m_ptr = (w + 1) % 4;
      end
      req = mask;
      for (int n = 0; n < 100 && ack_q.size() < order.size(); n++) tick();
      n_total++; if (ack_q.size() != order.size() || setup_q.size() != order.size())
        $display("FAIL rnd%0d_count: got %0d/%0d expected %0d", r, ack_q.size(), setup_q.size(), order.size()); else n_pass++;
      for (int g = 0; g < order.size() && g < ack_q.size() && g < setup_q.size(); g++) begin
        int id;
        id = order[g];
        n_total++; if (ack_q[g].id != id) $display("FAIL rnd%0d_id%0d: got %0d expected %0d", r, g, ack_q[g].id, id); else n_pass++;
        n_total++; if (setup_q[g].addr !== a_exp[id] || setup_q[g].rw !== rw_exp[id] || setup_q[g].wdata !== (rw_exp[id] ? d_exp[id] : 32'h0))
          $display("FAIL rnd%0d_bus%0d: got %h/%b/%h expected %h/%b/%h", r, g, setup_q[g].addr, setup_q[g].rw, setup_q[g].wdata,
                   a_exp[id], rw_exp[id], rw_exp[id] ? d_exp[id] : 32'h0); else n_pass++;
        n_total++; if (ack_q[g].err !== a_exp[id][2] || ack_q[g].rdata !== (rw_exp[id] ? 32'h0 : (a_exp[id] ^ KEY)))
          $display("FAIL rnd%0d_resp%0d: got %b/%h expected %b/%h", r, g, ack_q[g].err, ack_q[g].rdata,
                   a_exp[id][2], rw_exp[id] ? 32'h0 : (a_exp[id] ^ KEY)); else n_pass++;
      end
    end
    n_total++; if (onehot_bad !== 0) $display("FAIL onehot: got %0d multi-bit acks expected 0", onehot_bad); else n_pass++;
    n_total++; if (stab_bad !== 0) $display("FAIL stable: got %0d unstable cycles expected 0", stab_bad); else n_pass++;
    slv_auto = 0; scramble = 0;
  endtask

  initial begin
    presetn = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_fairness();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB bus between NREQ local requesters (DMA, CPU bridge, debug).
- Each requester presents a single transfer; the block picks a winner round-robin, runs the APB SETUP/ACCESS sequence itself, and returns a completion pulse with read data and error status.
- Sits between the requester fabric and the APB slaves.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA, 32, APB data width
ADDR, 32, APB address width
TIMEOUT, 16, max ACCESS cycles waiting for pready (1..255); 0 = no timeout

Ports:
pclk  in  1  APB clock
presetn  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester transfer request; held high until ack
req_rw  in  NREQ  per-requester direction, 1=write 0=read
req_addr  in  NREQ*ADDR  per-requester address; requester i at bits [i*ADDR +: ADDR]
req_wdata  in  NREQ*DATA  per-requester write data, same packing
ack  out  NREQ  one-cycle completion pulse to granted requester
rdata  out  DATA  read data, valid while ack pulses
err  out  1  error flag, valid while ack pulses (pslverr or timeout)
gnt_id  out  clog2(NREQ)  index of current/last granted requester
paddr  out  ADDR  APB address
pwrite  out  1  APB direction
pwdata  out  DATA  APB write data
psel  out  1  APB select
penable  out  1  APB enable
pready  in  1  from slave
prdata  in  DATA  from slave
pslverr  in  1  from slave

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-transfer):
  - state=IDLE; all outputs 0; round-robin pointer=0; timeout counter=0.
  - In-flight transfer is dropped and produces no ack.
- FSM states and transitions:
  - IDLE: when any eligible req is high at the clock edge, go to SETUP. Latch the winner's addr/rw/wdata into paddr/pwrite/pwdata (pwdata=0 for reads) and the winner into gnt_id.
  - SETUP: psel=1, penable=0; go to ACCESS unconditionally.
  - ACCESS: psel=1, penable=1.
    - pready=1 at edge: go to IDLE. Pulse ack[gnt_id]=1 for exactly one cycle. rdata=prdata for reads, 0 for writes. err=pslverr.
    - pready=0: increment counter. If TIMEOUT!=0 and counter reaches TIMEOUT, go to IDLE with ack pulse, err=1, rdata=0.
- Bus timing:
  - paddr/pwrite/pwdata stay stable from SETUP through the last ACCESS cycle.
  - psel/penable/paddr/pwdata return to 0 in IDLE.
  - Requester inputs may change after grant without affecting the transfer.
- Latency: minimum 3 cycles from a req seen in IDLE to ack (SETUP, ACCESS, IDLE+ack). Each pready wait cycle adds one.
- Arbitration:
  - Round-robin; search starts at pointer, wrapping NREQ-1 -> 0.
  - On each grant to i, pointer=(i+1) mod NREQ.
  - Eligible = req[k] && !ack[k], so the requester being acked in this IDLE cycle is excluded. The requester must drop req on the edge after it sees ack.
- Back-to-back: another pending req is granted in the same IDLE cycle that carries the previous ack. The next SETUP follows immediately, giving 3-cycle throughput with zero-wait slaves.
- Simultaneous events:
  - Requests arriving during SETUP/ACCESS wait; no preemption.
  - Only one ack bit is ever high.
  - err and rdata hold their value until the next ack.
- Timeout counter is 8 bits, cleared on entry to SETUP.
- pslverr is sampled only when pready=1 in ACCESS.

Test Plan:
- Single write: req[0]=1, rw=1, addr=0x10, wdata=0xDEADBEEF, pready tied 1 -> psel on cycles 1-2, penable on cycle 2, pwdata=0xDEADBEEF, ack[0] on cycle 3, err=0.
- Read with waits: req[2] read of 0x40, pready low 3 ACCESS cycles, then high with prdata=0x12345678 -> ack[2] after 6 cycles, rdata=0x12345678, paddr stable throughout.
- Fairness: req[0], req[1], req[3] high simultaneously, pointer=0, zero-wait slave -> grant order 0,1,3. Acks 3 cycles apart. Re-raising req[0] after its ack is served after 3.
- Timeout: TIMEOUT=16, pready stuck 0 -> ACCESS for 16 cycles, then IDLE, ack pulse, err=1, rdata=0, psel drops.
- Slave error: pslverr=1 with pready=1 on a write -> ack with err=1. Next transfer with pslverr=0 -> err=0.
- Reset mid-ACCESS: deassert presetn during a wait state -> psel/penable/paddr/ack immediately 0. After release, pending req[1] is granted first (pointer=0, req[0] low).
